// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter and one-shot access sequencer for the data memory.
// Each winning request runs IDLE -> ACCESS -> RESP; out-of-range accesses never reach the memory.
module dmem_arbiter #(
    parameter int unsigned DATA_W    = 64,
    parameter int unsigned ADDR_W    = 64,
    parameter int unsigned MEM_BYTES = 512
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_gnt,
    output logic              p0_done,
    output logic              p0_err,
    output logic [DATA_W-1:0] p0_rdata,

    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_gnt,
    output logic              p1_done,
    output logic              p1_err,
    output logic [DATA_W-1:0] p1_rdata,

    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_write_data,
    input  logic [DATA_W-1:0] mem_read_data
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_RESP   = 2'd2;

    localparam logic [ADDR_W-1:0] LAST_LEGAL = ADDR_W'(MEM_BYTES - 8);

    logic [1:0]        state_q,      state_d;
    logic              last_grant_q, last_grant_d;
    logic              win_q,        win_d;
    logic              we_q,         we_d;
    logic [ADDR_W-1:0] addr_q,       addr_d;
    logic [DATA_W-1:0] wdata_q,      wdata_d;
    logic              range_ok_q,   range_ok_d;
    logic [DATA_W-1:0] rdata0_q,     rdata0_d;
    logic [DATA_W-1:0] rdata1_q,     rdata1_d;

    logic              grant_valid;
    logic              grant_id;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic [DATA_W-1:0] captured;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        win_d        = win_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        range_ok_d   = range_ok_q;
        rdata0_d     = rdata0_q;
        rdata1_d     = rdata1_q;

        grant_valid  = p0_req | p1_req;
        // On a tie the port that did not win last time is served.
        if (p0_req && p1_req) begin
            grant_id = ~last_grant_q;
        end else begin
            grant_id = p1_req;
        end
        sel_we    = grant_id ? p1_we    : p0_we;
        sel_addr  = grant_id ? p1_addr  : p0_addr;
        sel_wdata = grant_id ? p1_wdata : p0_wdata;
        captured  = (range_ok_q && !we_q) ? mem_read_data : '0;

        case (state_q)
            S_IDLE: begin
                if (grant_valid) begin
                    win_d        = grant_id;
                    last_grant_d = grant_id;
                    we_d         = sel_we;
                    addr_d       = sel_addr;
                    wdata_d      = sel_wdata;
                    range_ok_d   = (sel_addr <= LAST_LEGAL);
                    state_d      = S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (win_q) begin
                    rdata1_d = captured;
                end else begin
                    rdata0_d = captured;
                end
                state_d = S_RESP;
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            last_grant_q <= 1'b1;
            win_q        <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            range_ok_q   <= 1'b0;
            rdata0_q     <= '0;
            rdata1_q     <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            win_q        <= win_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            range_ok_q   <= range_ok_d;
            rdata0_q     <= rdata0_d;
            rdata1_q     <= rdata1_d;
        end
    end

    // Outputs decode only from registered state, so an asynchronous reset clears them at once.
    logic in_access;
    logic in_resp;

    always_comb begin
        in_access      = (state_q == S_ACCESS);
        in_resp        = (state_q == S_RESP);

        p0_gnt         = in_access & ~win_q;
        p1_gnt         = in_access &  win_q;
        p0_done        = in_resp   & ~win_q;
        p1_done        = in_resp   &  win_q;
        p0_err         = in_resp   & ~win_q & ~range_ok_q;
        p1_err         = in_resp   &  win_q & ~range_ok_q;
        p0_rdata       = rdata0_q;
        p1_rdata       = rdata1_q;

        mem_read       = in_access & range_ok_q & ~we_q;
        mem_write      = in_access & range_ok_q &  we_q;
        mem_address    = in_access ? addr_q  : '0;
        mem_write_data = in_access ? wdata_q : '0;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-port round-robin arbiter and access sequencer in front of the 64-bit, byte-addressed, little-endian data memory (combinational read, write on posedge clk).
- Port 0 is the core load/store path; port 1 is the debug/DMA loader.
- The arbiter latches one winning request, drives the memory for exactly one cycle, and returns a registered response.
- Out-of-range accesses are blocked and flagged with an error.

Parameters:
- DATA_W, 64, data width of each port and of the memory word.
- ADDR_W, 64, address width of each port and of the memory address.
- MEM_BYTES, 512, memory size in bytes. A legal access satisfies addr <= MEM_BYTES-8 (all 8 bytes in range).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- p0_req  in  1  port-0 request; held high until p0_gnt is seen.
- p0_we  in  1  port-0 write (1) / read (0).
- p0_addr  in  ADDR_W  port-0 byte address.
- p0_wdata  in  DATA_W  port-0 write data.
- p0_gnt  out  1  one-cycle pulse: request latched.
- p0_done  out  1  one-cycle pulse: access complete.
- p0_err  out  1  valid with p0_done: address out of range.
- p0_rdata  out  DATA_W  read data, valid with p0_done when the access was a read with no error.
- p1_req, p1_we, p1_addr, p1_wdata, p1_gnt, p1_done, p1_err, p1_rdata: same definitions for port 1.
- mem_read  out  1  to memory.
- mem_write  out  1  to memory.
- mem_address  out  ADDR_W  to memory.
- mem_write_data  out  DATA_W  to memory.
- mem_read_data  in  DATA_W  from memory.

Behaviour:
- Reset:
  - State returns to IDLE and last_grant = 1, so port 0 wins the first tie.
  - All gnt/done/err outputs are 0; rdata = 0.
  - mem_read = mem_write = 0; mem_address = 0; mem_write_data = 0.
- FSM states: IDLE, ACCESS, RESP. Each state lasts exactly one cycle except IDLE.
- IDLE:
  - No req: stay in IDLE.
  - Exactly one req: that port wins.
  - Both req: the port != last_grant wins, and last_grant is updated.
  - On the edge, latch the winner's id, we, addr and wdata; compute range_ok = (addr <= MEM_BYTES-8); go to ACCESS.
- ACCESS:
  - winner_gnt = 1 for this cycle only.
  - Drive mem_address and mem_write_data from the latched values.
  - range_ok = 1: mem_write = we and mem_read = !we.
  - range_ok = 0: mem_read = mem_write = 0 (no memory side effects).
  - On the edge, capture rdata: mem_read_data for an in-range read, otherwise 0. Go to RESP.
- RESP:
  - winner_done = 1 and winner_err = !range_ok. The other port's done/err stay 0.
  - Memory outputs return to 0.
  - Next state is IDLE.
- Timing:
  - Request seen at IDLE edge T0: gnt in cycle T1, memory access in T1, done in T2.
  - Next arbitration is at the end of T3.
  - Peak throughput is one access per 3 cycles.
- Requester rule: drop req in the cycle after gnt is seen. A req still high in IDLE is treated as a new request.
- rdata holds its value until the next RESP for that port. Unused bits are never X.
- Addresses are unsigned. No alignment is required; any addr <= MEM_BYTES-8 is legal.
- Reset mid-operation: rst_n low during ACCESS forces mem_write low immediately (asynchronous). No write is committed, no gnt/done completes, and the pending request is discarded.
- Requests arriving during ACCESS/RESP are ignored until IDLE; a requester that keeps req high is served later.

Test Plan:
- Reset check: assert rst_n = 0 mid-cycle with both req high -> all outputs 0 asynchronously; after release, p0 wins first.
- Port 0 writes 0x1122334455667788 @0x10, then reads @0x10 -> p0_gnt, then p0_done 2 cycles after the request edge; p0_rdata = 0x1122334455667788, p0_err = 0.
- Both ports request continuously (p0 read @0x0, p1 read @0x8) -> grants alternate p0, p1, p0, p1 with one grant per 3 cycles; no done on the non-winning port.
- p1 alone issues back-to-back reads -> p1 granted every time; last_grant does not block a sole requester.
- p0 writes @504 (legal) and @505 (illegal) -> first sets memory[504..511]; second gives p0_err = 1, mem_write never high, and memory[505..511] unchanged.
- Pulse rst_n low during the ACCESS cycle of a write 0xDEADBEEF @0x20 -> memory @0x20 unchanged, no done, FSM in IDLE.
